// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, PC step and default vectors.
// The MISALIGN_TRAP_EN macro, used by pc_fetch_ctrl, selects the misaligned-branch trap build.
package cpu_defs_pkg;

   typedef enum logic [1:0] {
      RST_IDLE = 2'b00,
      FETCH    = 2'b01,
      WAIT_RSP = 2'b10
   } fetch_state_t;

   localparam logic [31:0] PC_INC       = 32'h0000_0004;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0004;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Fetch sequencing: tracks the single outstanding request, the stale-response
// discard flag, and decides when a request may be issued or a response loaded.
module fetch_fsm
   import cpu_defs_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic br_taken,
   input  logic stall,
   input  logic if_valid,
   input  logic imem_gnt,
   input  logic imem_rvalid,
   output logic imem_req,
   output logic grant_fire,
   output logic load_rsp
);

   fetch_state_t state_r;
   logic         discard_r;
   logic         imem_req_s;
   logic         load_rsp_s;

   // Request gating and response acceptance
   always_comb begin
      imem_req_s = 1'b0;
      load_rsp_s = 1'b0;
      if ((state_r == FETCH) && (!if_valid || !stall) && !br_taken) begin
         imem_req_s = 1'b1;
      end else begin
         imem_req_s = 1'b0;
      end
      // A redirect in the same cycle as the response makes that response stale
      if ((state_r == WAIT_RSP) && imem_rvalid && !discard_r && !br_taken) begin
         load_rsp_s = 1'b1;
      end else begin
         load_rsp_s = 1'b0;
      end
   end

   // State and discard-flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= RST_IDLE;
         discard_r <= 1'b0;
      end else begin
         case (state_r)
            RST_IDLE: begin
               state_r   <= FETCH;
               discard_r <= 1'b0;
            end
            FETCH: begin
               discard_r <= 1'b0;
               if (imem_req_s && imem_gnt) begin
                  state_r <= WAIT_RSP;
               end else begin
                  state_r <= FETCH;
               end
            end
            WAIT_RSP: begin
               if (imem_rvalid) begin
                  state_r   <= FETCH;
                  discard_r <= 1'b0;
               end else if (br_taken) begin
                  state_r   <= WAIT_RSP;
                  discard_r <= 1'b1;
               end else begin
                  state_r   <= WAIT_RSP;
                  discard_r <= discard_r;
               end
            end
            default: begin
               state_r   <= RST_IDLE;
               discard_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req   = imem_req_s;
   assign grant_fire = imem_req_s && imem_gnt;
   assign load_rsp   = load_rsp_s;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: PC register, IF/ID holding registers and redirect.
// Define MISALIGN_TRAP_EN to trap misaligned branch targets to TRAP_VEC.
module pc_fetch_ctrl
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign_trap,
`endif
   output logic        flush_id
);

   logic [31:0] pc_r;
   logic [31:0] inflight_pc_r;
   logic        if_valid_r;
   logic [31:0] if_pc_r;
   logic [31:0] if_inst_r;
   logic [31:0] redirect_pc_s;
   logic        grant_fire_s;
   logic        load_rsp_s;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_s;
   logic        misalign_trap_r;
`endif

   fetch_fsm u_fetch_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .br_taken    (br_taken),
      .stall       (stall),
      .if_valid    (if_valid_r),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_req    (imem_req),
      .grant_fire  (grant_fire_s),
      .load_rsp    (load_rsp_s)
   );

   // Redirect target selection
   always_comb begin
`ifdef MISALIGN_TRAP_EN
      if (br_pc[1:0] != 2'b00) begin
         redirect_pc_s = TRAP_VEC;
         misalign_s    = 1'b1;
      end else begin
         redirect_pc_s = br_pc;
         misalign_s    = 1'b0;
      end
`else
      redirect_pc_s = word_align(br_pc);
`endif
   end

   // PC and in-flight PC registers; a redirect always overrides the increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= RESET_PC;
         inflight_pc_r <= 32'h0000_0000;
      end else if (br_taken) begin
         pc_r          <= redirect_pc_s;
         inflight_pc_r <= inflight_pc_r;
      end else if (grant_fire_s) begin
         pc_r          <= pc_r + PC_INC;
         inflight_pc_r <= pc_r;
      end else begin
         pc_r          <= pc_r;
         inflight_pc_r <= inflight_pc_r;
      end
   end

   // IF/ID holding registers: held under stall, dropped once consumed or flushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_r <= 1'b0;
         if_pc_r    <= 32'h0000_0000;
         if_inst_r  <= 32'h0000_0000;
      end else if (br_taken) begin
         if_valid_r <= 1'b0;
      end else if (load_rsp_s) begin
         if_valid_r <= 1'b1;
         if_pc_r    <= inflight_pc_r;
         if_inst_r  <= imem_rdata;
      end else if (!stall) begin
         if_valid_r <= 1'b0;
      end else begin
         if_valid_r <= if_valid_r;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // One-cycle trap pulse following a misaligned redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_trap_r <= 1'b0;
      end else begin
         misalign_trap_r <= br_taken && misalign_s;
      end
   end

   assign misalign_trap = misalign_trap_r;
`endif

   assign imem_addr = pc_r;
   assign if_valid  = if_valid_r;
   assign if_pc     = if_pc_r;
   assign if_inst   = if_inst_r;
   assign flush_id  = br_taken;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0004, redirect target for misaligned branch (MISALIGN_TRAP_EN only).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port br_taken  input  1  EX-stage redirect request, single-cycle pulse.
REQ-006 SHALL have port br_pc  input  32  redirect target from the branch-target select stage.
REQ-007 SHALL have port stall  input  1  ID not accepting; held if_* outputs must not change.
REQ-008 SHALL have port imem_req  output  1  fetch request valid.
REQ-009 SHALL have port imem_addr  output  32  fetch address; stable while imem_req high and not granted.
REQ-010 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  response valid, earliest one cycle after grant.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-013 SHALL have port if_valid  output  1  IF/ID slot holds a valid instruction.
REQ-014 SHALL have port if_pc  output  32  PC of held instruction.
REQ-015 SHALL have port if_inst  output  32  held instruction word.
REQ-016 SHALL have port flush_id  output  1  combinational, equals br_taken; clears downstream ID/EX.
REQ-017 SHALL have port misalign_trap  output  1  registered one-cycle trap pulse (MISALIGN_TRAP_EN only).

Function
REQ-018 SHALL implement FSM states RST_IDLE, FETCH, WAIT_RSP; at most one request outstanding.
REQ-019 RST_IDLE SHALL last exactly one cycle after rst_n deasserts, imem_req=0, then go to FETCH.
REQ-020 In FETCH, imem_req SHALL be 1 with imem_addr=pc iff (!if_valid || !stall) and !br_taken.
REQ-021 On imem_req && imem_gnt: SHALL latch inflight_pc=pc, pc<=pc+4 (mod 2^32 wrap), go to WAIT_RSP.
REQ-022 In WAIT_RSP on imem_rvalid with discard=0: if_inst<=imem_rdata, if_pc<=inflight_pc, if_valid<=1, go to FETCH.
REQ-023 In WAIT_RSP on imem_rvalid with discard=1: response dropped, discard<=0, if_* unchanged, go to FETCH.
REQ-024 if_valid SHALL clear on cycle after !stall with no new response loaded; held values stable while stall=1.
REQ-025 br_taken SHALL set pc<=br_pc, if_valid<=0, regardless of stall (redirect wins).
REQ-026 br_taken while in WAIT_RSP, or coincident with a grant, SHALL set discard<=1 so the stale response is dropped.
REQ-027 br_taken coincident with imem_rvalid SHALL drop that response.
REQ-028 Redirect latency: br_taken at cycle N -> imem_req with imem_addr=br_pc at N+1 if nothing outstanding; if_valid earliest N+3 with zero-wait memory.
REQ-029 Sustained throughput with zero-wait memory and no stall: one instruction per two cycles.

Reset
REQ-030 On rst_n=0: state=RST_IDLE, pc=RESET_PC, discard=0, imem_req=0, if_valid=0, if_pc=0, if_inst=0, misalign_trap=0.
REQ-031 Reset mid-request SHALL abandon the outstanding transaction; any later rvalid before first new grant is ignored.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: br_taken with br_pc[1:0]!=0 sets pc<=TRAP_VEC, discards as REQ-026, pulses misalign_trap next cycle.
REQ-033 Macro undefined: misalign_trap port absent, br_pc[1:0] ignored (forced to 2'b00), TRAP_VEC unused.

Structure
REQ-034 Shared package cpu_defs_pkg SHALL hold fetch state encoding, PC_INC=4, default RESET_PC and TRAP_VEC constants.
REQ-035 Sub-module fetch_fsm SHALL hold state, discard flag and request gating; pc and IF/ID registers stay in top.

Verification
REQ-036 Reset release, gnt tied 1, rvalid one cycle after gnt -> imem_addr 0x0,0x4,0x8; if_pc follows, 2 cycles each.
REQ-037 stall=1 while if_valid=1, if_pc=0x8 -> imem_req=0, if_pc/if_inst hold until stall drops.
REQ-038 br_taken with br_pc=0x100 while WAIT_RSP for 0xC -> 0xC response dropped, next imem_addr=0x100, flush_id=1 same cycle.
REQ-039 br_taken and imem_rvalid same cycle, br_pc=0x200 -> if_valid=0, next if_pc=0x200.
REQ-040 MISALIGN_TRAP_EN, br_pc=0x102 -> misalign_trap pulse, next imem_addr=0x4; macro off -> next imem_addr=0x100.
REQ-041 rst_n low while WAIT_RSP, rvalid arrives during reset -> all outputs at reset values, fetch restarts at RESET_PC.
